arm_div_unit: RTL and testbench

- Iterative multi-cycle integer divider for ARMv8 UDIV/SDIV in the execute stage.
- Sits directly downstream of the register file: consumes its two read operands (rn as dividend, rm as divisor).
- Feeds the register-file write port: produces the write data, the destination index and the write enable.
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/arm_div_pkg.sv | 7 +
 rtl/arm_div_if.sv | 32 +++
 rtl/arm_div_step.sv | 21 ++
 rtl/arm_div_unit.sv | 108 ++++++++++
 tb/tb_arm_div_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/arm_div_pkg.sv
// arm_div_pkg: shared FSM states and iteration constants for the ARMv8 divider.
package arm_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int ITER_X = 64;
  localparam int ITER_W = 32;
  localparam int CNT_W = 7;
endpackage

// File: rtl/arm_div_if.sv
// arm_div_if: request/response bundle between register file, divider and write port.
// DIV_REM_EN adds the remainder signal.
interface arm_div_if #(parameter int DATA_W = 64, parameter int REG_AW = 5);
  logic start;
  logic is_signed;
  logic sf;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_AW-1:0] rd_in;
  logic busy;
  logic done;
  logic regwr;
  logic [REG_AW-1:0] rd_out;
  logic [DATA_W-1:0] result;
`ifdef DIV_REM_EN
  logic [DATA_W-1:0] remainder;
`endif
  modport master (
    output start, is_signed, sf, op_a, op_b, rd_in,
`ifdef DIV_REM_EN
    input remainder,
`endif
    input busy, done, regwr, rd_out, result
  );
  modport slave (
    input start, is_signed, sf, op_a, op_b, rd_in,
`ifdef DIV_REM_EN
    output remainder,
`endif
    output busy, done, regwr, rd_out, result
  );
endinterface

// File: rtl/arm_div_step.sv
// arm_div_step: one restoring iteration; shifts the next dividend bit into the
// remainder and retires one quotient bit.
module arm_div_step #(parameter int DATA_W = 64) (
  input  logic [DATA_W:0]   i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_div,
  output logic [DATA_W:0]   o_rem,
  output logic [DATA_W-1:0] o_quo
);
  logic [DATA_W:0] w_sh;
  logic [DATA_W:0] w_trial;
  logic w_ge;
  always_comb begin
    w_sh = {i_rem[DATA_W-1:0], i_quo[DATA_W-1]};
    w_trial = w_sh - {1'b0, i_div};
    // remainder stays below the divisor, so the trial MSB is the borrow
    w_ge = i_rem[DATA_W] | ~w_trial[DATA_W];
    o_rem = w_ge ? w_trial : w_sh;
    o_quo = {i_quo[DATA_W-2:0], w_ge};
  end
endmodule

// File: rtl/arm_div_unit.sv
// arm_div_unit: iterative radix-2 UDIV/SDIV for X- and W-form operands.
// Defining DIV_REM_EN adds a remainder output with dividend sign.
module arm_div_unit
  import arm_div_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic rst_n,
  arm_div_if.slave bus
);
  localparam int HW = DATA_W / 2;
  state_t r_state, w_next;
  logic r_done, r_sf, r_q_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W:0] r_rem;
  logic [DATA_W-1:0] r_quo, r_div, r_result;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_quo_nxt;
  logic [DATA_W:0] w_rem_nxt;
  logic w_a_neg, w_b_neg, w_b_zero, w_accept;
`ifdef DIV_REM_EN
  logic r_a_neg;
  logic [DATA_W-1:0] r_remainder;
  assign bus.remainder = r_remainder;
`endif
  function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v, input logic neg, input logic f);
    logic [DATA_W-1:0] t;
    t = neg ? -v : v;
    return f ? t : {{HW{1'b0}}, t[HW-1:0]};
  endfunction
  always_comb begin
    w_a_ext = bus.sf ? bus.op_a : {{HW{bus.is_signed & bus.op_a[HW-1]}}, bus.op_a[HW-1:0]};
    w_b_ext = bus.sf ? bus.op_b : {{HW{bus.is_signed & bus.op_b[HW-1]}}, bus.op_b[HW-1:0]};
    w_a_neg = bus.is_signed & w_a_ext[DATA_W-1];
    w_b_neg = bus.is_signed & w_b_ext[DATA_W-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_b_zero = w_b_ext == '0;
    w_accept = r_state == IDLE && bus.start;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? (w_b_zero ? FIX : RUN) : IDLE;
      RUN:     w_next = r_cnt == '0 ? FIX : RUN;
      FIX:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  arm_div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_div(r_div),
    .o_rem(w_rem_nxt),
    .o_quo(w_quo_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done <= 1'b0;
      r_sf <= 1'b0;
      r_q_neg <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_rd <= '0;
      r_result <= '0;
`ifdef DIV_REM_EN
      r_a_neg <= 1'b0;
      r_remainder <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done <= r_state == DONE;
      if (w_accept) begin
        r_sf <= bus.sf;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_rd <= bus.rd_in;
        r_div <= w_b_mag;
        // W-form dividend sits in the top half so its bits shift out first
        r_quo <= w_b_zero ? '0 : (bus.sf ? w_a_mag : {w_a_mag[HW-1:0], {HW{1'b0}}});
        r_rem <= w_b_zero ? {1'b0, w_a_mag} : '0;
        r_cnt <= bus.sf ? CNT_W'(ITER_X - 1) : CNT_W'(ITER_W - 1);
`ifdef DIV_REM_EN
        r_a_neg <= w_a_neg;
`endif
      end else if (r_state == RUN) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == FIX) begin
        r_result <= fix_sign(r_quo, r_q_neg, r_sf);
`ifdef DIV_REM_EN
        r_remainder <= fix_sign(r_rem[DATA_W-1:0], r_a_neg, r_sf);
`endif
      end
    end
  end
  assign bus.busy = r_state != IDLE || r_done;
  assign bus.done = r_done;
  assign bus.regwr = r_done;
  assign bus.rd_out = r_rd;
  assign bus.result = r_result;
endmodule

// File: tb/tb_arm_div_unit.sv
// tb_arm_div_unit: directed vectors for arm_div_unit with immediate-assertion checks.
module tb_arm_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int lat;
  int n_wr;
  arm_div_if #(.DATA_W(64), .REG_AW(5)) bus ();
  arm_div_unit #(.DATA_W(64), .REG_AW(5)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!bus.done && l < 200);
  endtask

  task automatic run(input logic s, input logic f, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, output int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.sf = f;
    bus.op_a = a;
    bus.op_b = b;
    bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy after accept", 64'(bus.busy), 64'd1);
    wait_done(l);
  endtask

  task automatic post(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.sf = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.rd_in = '0;
    #12;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst regwr", 64'(bus.regwr), 64'd0);
    chk("rst rd_out", 64'(bus.rd_out), 64'd0);
    chk("rst result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 1'b1, 64'd100, 64'd7, 5'd5, lat);
    chk("udiv x lat", 64'(lat), 64'd66);
    chk("udiv x result", bus.result, 64'd14);
    chk("udiv x regwr", 64'(bus.regwr), 64'd1);
    chk("udiv x rd_out", 64'(bus.rd_out), 64'd5);
    post("udiv x");

    run(1'b1, 1'b0, 64'h0000_0000_FFFF_FF9C, 64'd7, 5'd3, lat);
    chk("sdiv w lat", 64'(lat), 64'd34);
    chk("sdiv w result", bus.result, 64'h0000_0000_FFFF_FFF2);
    chk("sdiv w rd_out", 64'(bus.rd_out), 64'd3);
`ifdef DIV_REM_EN
    chk("sdiv w rem", bus.remainder, 64'h0000_0000_FFFF_FFFE);
`endif
    post("sdiv w");

    run(1'b0, 1'b1, 64'h1234, 64'd0, 5'd1, lat);
    chk("udiv0 lat", 64'(lat), 64'd2);
    chk("udiv0 result", bus.result, 64'd0);
`ifdef DIV_REM_EN
    chk("udiv0 rem", bus.remainder, 64'h1234);
`endif
    post("udiv0");
    run(1'b1, 1'b0, 64'h1234, 64'd0, 5'd2, lat);
    chk("sdiv0 lat", 64'(lat), 64'd2);
    chk("sdiv0 result", bus.result, 64'd0);
`ifdef DIV_REM_EN
    chk("sdiv0 rem", bus.remainder, 64'h1234);
`endif

    run(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, lat);
    chk("sdiv ovf x lat", 64'(lat), 64'd66);
    chk("sdiv ovf x result", bus.result, 64'h8000_0000_0000_0000);
`ifdef DIV_REM_EN
    chk("sdiv ovf x rem", bus.remainder, 64'd0);
`endif
    run(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10, lat);
    chk("sdiv ovf w result", bus.result, 64'h0000_0000_8000_0000);
    run(1'b0, 1'b0, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, 5'd11, lat);
    chk("udiv w hi ignored", bus.result, 64'd14);
    run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd12, lat);
    chk("sdiv x neg", bus.result, 64'hFFFF_FFFF_FFFF_FFF2);
`ifdef DIV_REM_EN
    chk("sdiv x rem", bus.remainder, 64'hFFFF_FFFF_FFFF_FFFE);
`endif
    run(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd13, lat);
    chk("udiv x max", bus.result, 64'h5555_5555_5555_5555);
    run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, lat);
    chk("sdiv x negneg", bus.result, 64'd14);
    post("sdiv negneg");

    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.sf = 1'b1;
    bus.op_a = 64'd1000;
    bus.op_b = 64'd10;
    bus.rd_in = 5'd7;
    @(posedge clk);
    #1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.op_a = {$urandom, $urandom};
      bus.op_b = {$urandom, $urandom};
      bus.rd_in = 5'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 200);
    chk("held start lat", 64'(lat), 64'd66);
    chk("held start result", bus.result, 64'd100);
    chk("held start rd_out", 64'(bus.rd_out), 64'd7);
    bus.op_a = 64'd50;
    bus.op_b = 64'd5;
    bus.rd_in = 5'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("reaccept busy", 64'(bus.busy), 64'd1);
    chk("reaccept done low", 64'(bus.done), 64'd0);
    wait_done(lat);
    chk("reaccept lat", 64'(lat), 64'd66);
    chk("reaccept result", bus.result, 64'd10);
    chk("reaccept rd_out", 64'(bus.rd_out), 64'd8);
    post("reaccept");

    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a = 64'd1000;
    bus.op_b = 64'd3;
    bus.rd_in = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort regwr", 64'(bus.regwr), 64'd0);
    chk("abort rd_out", 64'(bus.rd_out), 64'd0);
    chk("abort result", bus.result, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.regwr) n_wr++;
    end
    chk("abort no regwr", 64'(n_wr), 64'd0);
    run(1'b0, 1'b1, 64'd81, 64'd9, 5'd6, lat);
    chk("post reset lat", 64'(lat), 64'd66);
    chk("post reset result", bus.result, 64'd9);
    chk("post reset rd_out", 64'(bus.rd_out), 64'd6);
    post("post reset");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
